dqpsk_diff_decoder: RTL and testbench

//  Receive-side DQPSK differential decoder. It sits directly upstream of the

---
 rtl/dqpsk_pkg.sv | 38 +++
 rtl/dqpsk_phase_diff.sv | 35 +++
 rtl/dqpsk_diff_decoder.sv | 156 +++++++++++++++
 tb/tb_dqpsk_diff_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dqpsk_pkg.sv
// Shared types and helpers for the DQPSK differential decoder.
// Quadrant numbering follows the receive slicer's sign convention (1 = negative).
package dqpsk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  function automatic logic [1:0] quadrant(input logic i_neg, input logic q_neg);
    logic [1:0] quad;
    case ({i_neg, q_neg})
      2'b00:   quad = QUAD_0;
      2'b10:   quad = QUAD_1;
      2'b11:   quad = QUAD_2;
      default: quad = QUAD_3;
    endcase
    return quad;
  endfunction

  function automatic logic [1:0] gray_demap(input logic [1:0] delta);
    logic [1:0] dibit;
    case (delta)
      2'd0:    dibit = 2'b00;
      2'd1:    dibit = 2'b01;
      2'd2:    dibit = 2'b11;
      default: dibit = 2'b10;
    endcase
    return dibit;
  endfunction

endpackage

// File: rtl/dqpsk_phase_diff.sv
// Phase-difference stage: remembers the previous quadrant and presents the
// quadrant step and its Gray dibit combinationally for the current symbol.
module dqpsk_phase_diff
  import dqpsk_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_sign_i,
  input  logic       q_sign_i,
  input  logic       load_i,
  output logic [1:0] delta_o,
  output logic [1:0] dibit_o
);

  logic [1:0] quad;
  logic [1:0] prev_q;
  logic [1:0] prev_d;

  always_comb begin
    quad    = quadrant(i_sign_i, q_sign_i);
    // 2-bit subtraction gives the mod-4 phase step for free
    delta_o = quad - prev_q;
    dibit_o = gray_demap(delta_o);
    prev_d  = load_i ? quad : prev_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= QUAD_0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/dqpsk_diff_decoder.sv
// DQPSK differential decoder: hunts for a zero-phase-change preamble, then
// emits fixed-length frames of Gray-demapped dibits, aborting on starvation.
module dqpsk_diff_decoder
  import dqpsk_pkg::*;
#(
  parameter int SYNC_LEN   = 8,
  parameter int FRAME_SYMS = 64,
  parameter int MAX_GAP    = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sym_i_sign,
  input  logic       sym_q_sign,
  input  logic       sym_valid,
  output logic [1:0] data_par,
  output logic       dibit_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       sync_lock,
  output logic       err_flag
);

  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int PW = $clog2(FRAME_SYMS + 1);
  localparam int GW = $clog2(MAX_GAP + 1);

  // Terminal-minus-one compares let each counter stop exactly at its limit
  localparam logic [SW-1:0] SYNC_PRE = SW'(SYNC_LEN - 2);
  localparam logic [PW-1:0] PAY_LAST = PW'(FRAME_SYMS - 1);
  localparam logic [GW-1:0] GAP_PRE  = GW'(MAX_GAP - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   sync_cnt_q, sync_cnt_d;
  logic [PW-1:0]   pay_cnt_q, pay_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            fs_q, fs_d;
  logic            fe_q, fe_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic            timeout;
  logic [1:0]      delta;
  logic [1:0]      dibit;

  dqpsk_phase_diff u_phase_diff (
    .clk_i    (clk_in),
    .rst_i    (rst),
    .i_sign_i (sym_i_sign),
    .q_sign_i (sym_q_sign),
    .load_i   (sym_valid),
    .delta_o  (delta),
    .dibit_o  (dibit)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_cnt_q <= '0;
      pay_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      data_q     <= 2'b00;
      dv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        gap_cnt_d = '0;
        if (sym_valid) begin
          state_d    = HUNT;
          sync_cnt_d = '0;
        end
      end
      HUNT: begin
        gap_cnt_d = '0;
        if (sym_valid) begin
          if (delta == 2'd0) begin
            sync_cnt_d = sync_cnt_q + 1'b1;
            if (sync_cnt_q == SYNC_PRE) begin
              state_d   = PAYLOAD;
              pay_cnt_d = '0;
            end
          end else begin
            sync_cnt_d = '0;
          end
        end
      end
      PAYLOAD: begin
        // A strobe on the would-be timeout cycle takes priority
        if (sym_valid) begin
          gap_cnt_d = '0;
          if (pay_cnt_q == PAY_LAST) begin
            state_d    = HUNT;
            sync_cnt_d = '0;
            pay_cnt_d  = '0;
          end else begin
            pay_cnt_d = pay_cnt_q + 1'b1;
          end
        end else if (gap_cnt_q == GAP_PRE) begin
          state_d   = IDLE;
          timeout   = 1'b1;
          gap_cnt_d = '0;
          pay_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    dv_d   = 1'b0;
    fs_d   = 1'b0;
    fe_d   = 1'b0;
    err_d  = timeout;
    lock_d = (state_d == PAYLOAD);
    if ((state_q == PAYLOAD) && sym_valid) begin
      data_d = dibit;
      dv_d   = 1'b1;
      fs_d   = (pay_cnt_q == '0);
      fe_d   = (pay_cnt_q == PAY_LAST);
    end
  end

  assign data_par    = data_q;
  assign dibit_valid = dv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign sync_lock   = lock_q;
  assign err_flag    = err_q;

endmodule

// File: tb/tb_dqpsk_diff_decoder.sv
// Bench for dqpsk_diff_decoder: directed scenarios plus random traffic,
// every cycle compared against an integer-level behavioural model.
module tb_dqpsk_diff_decoder;

  localparam int SYNC_LEN   = 8;
  localparam int FRAME_SYMS = 4;
  localparam int MAX_GAP    = 16;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       sym_i_sign = 1'b0;
  logic       sym_q_sign = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] data_par;
  logic       dibit_valid, frame_start, frame_end, sync_lock, err_flag;

  dqpsk_diff_decoder #(
    .SYNC_LEN   (SYNC_LEN),
    .FRAME_SYMS (FRAME_SYMS),
    .MAX_GAP    (MAX_GAP)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sym_i_sign  (sym_i_sign),
    .sym_q_sign  (sym_q_sign),
    .sym_valid   (sym_valid),
    .data_par    (data_par),
    .dibit_valid (dibit_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .sync_lock   (sync_lock),
    .err_flag    (err_flag)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = waiting for first symbol, 1 = hunting, 2 = in frame
  int         m_mode, m_prev, m_zeros, m_idx, m_quiet;
  logic [1:0] e_data;
  logic       e_dv, e_fs, e_fe, e_lock, e_err;

  logic [6:0] obs, exp_v;
  assign obs   = {data_par, dibit_valid, frame_start, frame_end, sync_lock, err_flag};
  assign exp_v = {e_data, e_dv, e_fs, e_fe, e_lock, e_err};

  function automatic logic [1:0] gray_of(input int d);
    case (d)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_zeros = 0; m_idx = 0; m_quiet = 0;
    e_data = 2'b00; e_dv = 0; e_fs = 0; e_fe = 0; e_lock = 0; e_err = 0;
  endtask

  task automatic model_step(input logic v, input int quad);
    int d;
    e_dv = 0; e_fs = 0; e_fe = 0; e_err = 0;
    d = (quad - m_prev + 4) % 4;
    if (v) m_prev = quad;
    if (m_mode == 0) begin
      if (v) begin m_mode = 1; m_zeros = 0; end
    end else if (m_mode == 1) begin
      if (v) begin
        m_zeros = (d == 0) ? m_zeros + 1 : 0;
        if (m_zeros == SYNC_LEN - 1) begin m_mode = 2; m_idx = 0; m_quiet = 0; end
      end
    end else begin
      if (v) begin
        e_data = gray_of(d); e_dv = 1;
        e_fs = (m_idx == 0); e_fe = (m_idx == FRAME_SYMS - 1);
        m_idx++; m_quiet = 0;
        if (m_idx == FRAME_SYMS) begin m_mode = 1; m_zeros = 0; end
      end else begin
        m_quiet++;
        if (m_quiet == MAX_GAP) begin e_err = 1; m_mode = 0; end
      end
    end
    e_lock = (m_mode == 2);
  endtask

  // Drives one cycle; signs are the inverse of the quadrant table
  task automatic tick(input logic v, input int quad);
    sym_valid  = v;
    sym_i_sign = (quad == 1) || (quad == 2);
    sym_q_sign = (quad == 2) || (quad == 3);
    @(posedge clk_in);
    if (rst) model_reset(); else model_step(v, quad);
    #1;
  endtask

  task automatic test_reset_state();
    repeat (3) tick(1'b1, 2);
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", obs, 7'b0);
    end
    rst = 1'b0;
    tick(1'b0, 0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++; $display("FAIL reset_idle: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_lock();
    for (int k = 0; k < SYNC_LEN; k++) begin
      int ngap = $urandom_range(0, 20);
      for (int g = 0; g < ngap; g++) begin
        tick(1'b0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++; $display("FAIL lock_gap k=%0d: got %b want %b", k, obs, exp_v);
        end
      end
      tick(1'b1, 0);
      n_cmp++;
      if (obs !== exp_v || dibit_valid !== 1'b0 || sync_lock !== (k == SYNC_LEN - 1)) begin
        n_bad++; $display("FAIL lock k=%0d: got %b want %b lock_req %0d", k, obs, exp_v, k == SYNC_LEN - 1);
      end
    end
  endtask

  task automatic test_demap();
    int quads[4] = '{1, 3, 3, 0};
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, quads[k]);
      n_cmp++;
      if (obs !== exp_v || dibit_valid !== 1'b1 || frame_start !== (k == 0) || frame_end !== (k == 3)) begin
        n_bad++; $display("FAIL demap k=%0d: got %b want %b", k, obs, exp_v);
      end
      tick(1'b0, quads[k]);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL demap_hold k=%0d: got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap_frame();
    for (int k = 0; k < SYNC_LEN + FRAME_SYMS + 1; k++) begin
      int quad = (k < SYNC_LEN) ? 3 : (k == SYNC_LEN) ? 0 : $urandom_range(0, 3);
      tick(1'b1, quad);
      n_cmp++;
      if (obs !== exp_v || (k == SYNC_LEN && data_par !== 2'b01)
          || (k == SYNC_LEN + FRAME_SYMS - 1 && (frame_end !== 1'b1 || sync_lock !== 1'b0))
          || (k == SYNC_LEN + FRAME_SYMS && dibit_valid !== 1'b0)) begin
        n_bad++; $display("FAIL wrap_frame k=%0d: got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_broken_preamble();
    int deltas[12] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, (m_prev + deltas[k]) % 4);
      n_cmp++;
      if (obs !== exp_v || sync_lock !== (k == 11)) begin
        n_bad++; $display("FAIL broken_preamble k=%0d: got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_starvation();
    int gaps[2] = '{MAX_GAP - 1, MAX_GAP};
    tick(1'b1, $urandom_range(0, 3));
    for (int r = 0; r < 2; r++) begin
      for (int g = 1; g <= gaps[r]; g++) begin
        tick(1'b0, 0);
        n_cmp++;
        if (obs !== exp_v || err_flag !== (r == 1 && g == MAX_GAP)
            || sync_lock !== !(r == 1 && g == MAX_GAP)) begin
          n_bad++; $display("FAIL starvation r=%0d g=%0d: got %b want %b", r, g, obs, exp_v);
        end
      end
      tick(1'b1, $urandom_range(0, 3));
      n_cmp++;
      if (obs !== exp_v || dibit_valid !== (r == 0) || err_flag !== 1'b0) begin
        n_bad++; $display("FAIL starvation_sym r=%0d: got %b want %b", r, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < SYNC_LEN + 2; k++) begin
      tick(1'b1, (k < SYNC_LEN) ? 2 : $urandom_range(0, 3));
    end
    n_cmp++;
    if (obs !== exp_v || sync_lock !== 1'b1) begin
      n_bad++; $display("FAIL reset_pre: got %b want %b", obs, exp_v);
    end
    #3 rst = 1'b1;
    #1 model_reset();
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL reset_async: got %b want %b", obs, 7'b0);
    end
    tick(1'b1, 1);
    rst = 1'b0;
    for (int k = 0; k < SYNC_LEN + 1; k++) begin
      tick(1'b1, 1);
      n_cmp++;
      if (obs !== exp_v || (k == 0 && dibit_valid !== 1'b0)) begin
        n_bad++; $display("FAIL reset_after k=%0d: got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 1500; it++) begin
      int ngap = ($urandom_range(0, 19) == 0) ? $urandom_range(MAX_GAP - 2, MAX_GAP + 1)
                                              : $urandom_range(0, 2);
      int quad = (m_mode == 1 && $urandom_range(0, 9) != 0) ? m_prev : $urandom_range(0, 3);
      for (int g = 0; g < ngap; g++) begin
        tick(1'b0, 0);
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++; $display("FAIL random_gap it=%0d: got %b want %b", it, obs, exp_v);
        end
      end
      tick(1'b1, quad);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL random_sym it=%0d: got %b want %b", it, obs, exp_v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset_state();
    test_lock();
    test_demap();
    test_wrap_frame();
    test_broken_preamble();
    test_starvation();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
